seven_seg_scan_driver: RTL and testbench

//  Time-multiplexed N-digit seven-segment driver for the stopwatch display. Parametrised successor of the

---
 rtl/seven_seg_pkg.sv | 36 +++
 rtl/seven_seg_scan_driver_if.sv | 39 +++
 rtl/hex_to_seg.sv | 39 +++
 rtl/seven_seg_scan_driver.sv | 240 ++++++++++++++++++++++++
 tb/tb_seven_seg_scan_driver.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/seven_seg_pkg.sv
// -----------------------------------------------------------------------------
// seven_seg_pkg
// Shared definitions for the seven-segment display path.
//   - Segment bit order of the 8-bit pin bus: {dp,g,f,e,d,c,b,a}, a = bit 0.
//   - 7-bit active-high glyph constants for 0-9, A, b, C, d, E, F and blank.
//     Bit 0 = segment a ... bit 6 = segment g.
// -----------------------------------------------------------------------------
package seven_seg_pkg;

  // Width of the full pin bus (7 segments plus decimal point).
  localparam int SEG_W      = 8;
  // Width of a glyph (segments a..g only).
  localparam int GLYPH_W    = 7;
  // Position of the decimal point in the pin bus.
  localparam int SEG_DP_BIT = 7;

  // Glyphs, active high, {g,f,e,d,c,b,a}.
  localparam logic [GLYPH_W-1:0] SEG_0     = 7'h3F;  // a b c d e f
  localparam logic [GLYPH_W-1:0] SEG_1     = 7'h06;  // b c
  localparam logic [GLYPH_W-1:0] SEG_2     = 7'h5B;  // a b d e g
  localparam logic [GLYPH_W-1:0] SEG_3     = 7'h4F;  // a b c d g
  localparam logic [GLYPH_W-1:0] SEG_4     = 7'h66;  // b c f g
  localparam logic [GLYPH_W-1:0] SEG_5     = 7'h6D;  // a c d f g
  localparam logic [GLYPH_W-1:0] SEG_6     = 7'h7D;  // a c d e f g
  localparam logic [GLYPH_W-1:0] SEG_7     = 7'h07;  // a b c
  localparam logic [GLYPH_W-1:0] SEG_8     = 7'h7F;  // all
  localparam logic [GLYPH_W-1:0] SEG_9     = 7'h6F;  // a b c d f g
  localparam logic [GLYPH_W-1:0] SEG_A     = 7'h77;  // a b c e f g
  localparam logic [GLYPH_W-1:0] SEG_B     = 7'h7C;  // c d e f g  (lower-case b)
  localparam logic [GLYPH_W-1:0] SEG_C     = 7'h39;  // a d e f
  localparam logic [GLYPH_W-1:0] SEG_D     = 7'h5E;  // b c d e g  (lower-case d)
  localparam logic [GLYPH_W-1:0] SEG_E     = 7'h79;  // a d e f g
  localparam logic [GLYPH_W-1:0] SEG_F     = 7'h71;  // a e f g
  localparam logic [GLYPH_W-1:0] SEG_BLANK = 7'h00;

endpackage : seven_seg_pkg

// File: rtl/seven_seg_scan_driver_if.sv
// -----------------------------------------------------------------------------
// seven_seg_scan_driver_if
// Bundle between the stopwatch datapath / board pins and the scan driver.
//   number      datapath -> driver  4*NUM_DIGITS  nibble k = digit k (digit 0 rightmost)
//   dp_mask     datapath -> driver  NUM_DIGITS    1 = decimal point of digit k lit
//   blink_mask  datapath -> driver  NUM_DIGITS    1 = digit k blinks
//   blank_lz    datapath -> driver  1             leading-zero blanking enable
//   brightness  datapath -> driver  4             0 = dark ... 15 = full on
//   io_sel      driver -> pins      NUM_DIGITS    one-hot digit select
//   io_seg      driver -> pins      8             {dp,g,f,e,d,c,b,a}
//   frame_start driver -> datapath  1             pulse when the scan wraps to digit 0
// master = side that supplies the display data, slave = the scan driver.
// -----------------------------------------------------------------------------
interface seven_seg_scan_driver_if
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS = 4
);

  logic [4*NUM_DIGITS-1:0] number;
  logic [NUM_DIGITS-1:0]   dp_mask;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic                    blank_lz;
  logic [3:0]              brightness;
  logic [NUM_DIGITS-1:0]   io_sel;
  logic [SEG_W-1:0]        io_seg;
  logic                    frame_start;

  modport master (
    output number, dp_mask, blink_mask, blank_lz, brightness,
    input  io_sel, io_seg, frame_start
  );

  modport slave (
    input  number, dp_mask, blink_mask, blank_lz, brightness,
    output io_sel, io_seg, frame_start
  );

endinterface : seven_seg_scan_driver_if

// File: rtl/hex_to_seg.sv
// -----------------------------------------------------------------------------
// hex_to_seg
// Combinational nibble -> seven-segment glyph decoder (active high, no DP).
//   nibble  in   4  value 0..F
//   seg     out  7  {g,f,e,d,c,b,a}, 1 = segment lit
// Output polarity of the board is applied by the caller.
// -----------------------------------------------------------------------------
module hex_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0]         nibble,
  output logic [GLYPH_W-1:0] seg
);

  // Glyph lookup from the shared package table.
  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'hA:    seg = SEG_A;
      4'hB:    seg = SEG_B;
      4'hC:    seg = SEG_C;
      4'hD:    seg = SEG_D;
      4'hE:    seg = SEG_E;
      4'hF:    seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule : hex_to_seg

// File: rtl/seven_seg_scan_driver.sv
// -----------------------------------------------------------------------------
// seven_seg_scan_driver
// Time-multiplexed N-digit seven-segment driver with per-digit blink and DP
// masks, leading-zero blanking and 16-step PWM brightness.
//   clk   in  board clock
//   rst   in  synchronous, active-high reset
//   bus   seven_seg_scan_driver_if.slave
//         in : number, dp_mask, blink_mask, blank_lz, brightness
//         out: io_sel (one-hot, SEL_ACTIVE_LOW), io_seg ({dp,g..a}, SEG_ACTIVE_LOW),
//              frame_start (1-cycle pulse when the scan wraps to digit 0)
// All outputs are registered; io_sel/io_seg follow the digit index one cycle
// later. number/dp_mask/blink_mask/blank_lz are captured once per frame so a
// mid-frame update never tears the display; brightness is used live.
// -----------------------------------------------------------------------------
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int CLK_HZ         = 100_000_000,
  parameter int REFRESH_HZ     = 500,
  parameter int BLINK_HZ       = 1,
  parameter int SEL_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic clk,
  input  logic rst,
  seven_seg_scan_driver_if.slave bus
);

  // Slot and blink timing, both clamped so tiny clock ratios still work.
  localparam int SLOT_RAW = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
  localparam int SLOT_LEN = (SLOT_RAW < 1) ? 1 : SLOT_RAW;
  localparam int PRE_W    = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
  localparam int HALF_RAW = CLK_HZ / (2 * BLINK_HZ);
  localparam int HALF_LEN = (HALF_RAW < 1) ? 1 : HALF_RAW;
  localparam int BLK_W    = (HALF_LEN > 1) ? $clog2(HALF_LEN) : 1;
  localparam int IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SLOT_LEN - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(HALF_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  localparam logic [NUM_DIGITS-1:0] SEL_OFF =
    (SEL_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  localparam logic [SEG_W-1:0] SEG_OFF =
    (SEG_ACTIVE_LOW != 0) ? {SEG_W{1'b1}} : {SEG_W{1'b0}};

  // Scan / timing state.
  logic [PRE_W-1:0] presc_r;
  logic [IDX_W-1:0] idx_r;
  logic [3:0]       pwm_r;
  logic [BLK_W-1:0] blk_cnt_r;
  logic             blk_off_r;
  logic             first_r;      // first cycle after reset release

  // Frame snapshot.
  logic [4*NUM_DIGITS-1:0] sh_num_r;
  logic [NUM_DIGITS-1:0]   sh_dp_r;
  logic [NUM_DIGITS-1:0]   sh_blink_r;
  logic                    sh_blank_r;

  // Output registers.
  logic [NUM_DIGITS-1:0] sel_r;
  logic [SEG_W-1:0]      seg_r;
  logic                  frame_start_r;

  // Combinational helpers.
  logic                    presc_last_s;
  logic                    wrap_s;
  logic                    load_s;
  logic [4*NUM_DIGITS-1:0] view_num_s;
  logic [NUM_DIGITS-1:0]   view_dp_s;
  logic [NUM_DIGITS-1:0]   view_blink_s;
  logic                    view_blank_s;
  logic [NUM_DIGITS-1:0]   lz_mask_s;
  logic [3:0]              nib_s;
  logic [GLYPH_W-1:0]      glyph_s;
  logic [SEG_W-1:0]        pat_s;
  logic [SEG_W-1:0]        shown_s;
  logic [NUM_DIGITS-1:0]   onehot_s;
  logic                    digit_on_s;
  logic [NUM_DIGITS-1:0]   sel_nxt_s;
  logic [SEG_W-1:0]        seg_nxt_s;

  assign presc_last_s = (presc_r == PRE_LAST);
  // A frame ends when the last slot of the last digit expires.
  assign wrap_s       = presc_last_s && (idx_r == IDX_LAST);
  assign load_s       = wrap_s || first_r;

  // Prescaler and digit index: idx advances once per slot and wraps at the last digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_r <= {PRE_W{1'b0}};
      idx_r   <= {IDX_W{1'b0}};
    end else if (presc_last_s) begin
      presc_r <= {PRE_W{1'b0}};
      if (idx_r == IDX_LAST) begin
        idx_r <= {IDX_W{1'b0}};
      end else begin
        idx_r <= idx_r + IDX_W'(1);
      end
    end else begin
      presc_r <= presc_r + PRE_W'(1);
      idx_r   <= idx_r;
    end
  end

  // Free-running PWM counter and blink phase, independent of frame boundaries.
  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_r     <= 4'd0;
      blk_cnt_r <= {BLK_W{1'b0}};
      blk_off_r <= 1'b0;
    end else begin
      pwm_r <= pwm_r + 4'd1;
      if (blk_cnt_r == BLK_LAST) begin
        blk_cnt_r <= {BLK_W{1'b0}};
        blk_off_r <= ~blk_off_r;
      end else begin
        blk_cnt_r <= blk_cnt_r + BLK_W'(1);
        blk_off_r <= blk_off_r;
      end
    end
  end

  // Frame snapshot: loaded on the first cycle after reset and at every frame wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      first_r    <= 1'b1;
      sh_num_r   <= {(4*NUM_DIGITS){1'b0}};
      sh_dp_r    <= {NUM_DIGITS{1'b0}};
      sh_blink_r <= {NUM_DIGITS{1'b0}};
      sh_blank_r <= 1'b0;
    end else begin
      first_r <= 1'b0;
      if (load_s) begin
        sh_num_r   <= bus.number;
        sh_dp_r    <= bus.dp_mask;
        sh_blink_r <= bus.blink_mask;
        sh_blank_r <= bus.blank_lz;
      end else begin
        sh_num_r   <= sh_num_r;
        sh_dp_r    <= sh_dp_r;
        sh_blink_r <= sh_blink_r;
        sh_blank_r <= sh_blank_r;
      end
    end
  end

  // Display view: on the first cycle after reset the snapshot is still empty,
  // so digit 0 is rendered straight from the inputs being captured.
  always_comb begin
    if (first_r) begin
      view_num_s   = bus.number;
      view_dp_s    = bus.dp_mask;
      view_blink_s = bus.blink_mask;
      view_blank_s = bus.blank_lz;
    end else begin
      view_num_s   = sh_num_r;
      view_dp_s    = sh_dp_r;
      view_blink_s = sh_blink_r;
      view_blank_s = sh_blank_r;
    end
  end

  // Leading-zero mask: walk from the top digit down while every nibble so far is zero.
  always_comb begin
    logic zero_run_s;
    zero_run_s = 1'b1;
    lz_mask_s  = {NUM_DIGITS{1'b0}};
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run_s   = zero_run_s && (view_num_s[4*k +: 4] == 4'd0);
      lz_mask_s[k] = view_blank_s && zero_run_s && (k != 0);
    end
  end

  assign nib_s = view_num_s[4*int'(idx_r) +: 4];

  hex_to_seg u_hex_to_seg (
    .nibble (nib_s),
    .seg    (glyph_s)
  );

  // Next output values for the current digit: glyph, DP, blink, PWM gate, polarity.
  always_comb begin
    pat_s = {SEG_W{1'b0}};
    if (lz_mask_s[idx_r]) begin
      pat_s[GLYPH_W-1:0] = SEG_BLANK;
    end else begin
      pat_s[GLYPH_W-1:0] = glyph_s;
    end
    pat_s[SEG_DP_BIT] = view_dp_s[idx_r];

    // Blink off-phase darkens the whole digit including its DP.
    if (blk_off_r && view_blink_s[idx_r]) begin
      shown_s = {SEG_W{1'b0}};
    end else begin
      shown_s = pat_s;
    end

    onehot_s = {NUM_DIGITS{1'b0}};
    for (int k = 0; k < NUM_DIGITS; k++) begin
      onehot_s[k] = (idx_r == IDX_W'(k));
    end

    digit_on_s = (bus.brightness == 4'd15) || (pwm_r < bus.brightness);

    if (!digit_on_s) begin
      sel_nxt_s = SEL_OFF;
    end else if (SEL_ACTIVE_LOW != 0) begin
      sel_nxt_s = ~onehot_s;
    end else begin
      sel_nxt_s = onehot_s;
    end

    if (SEG_ACTIVE_LOW != 0) begin
      seg_nxt_s = ~shown_s;
    end else begin
      seg_nxt_s = shown_s;
    end
  end

  // Output registers: inactive during reset, otherwise one cycle behind idx.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_r         <= SEL_OFF;
      seg_r         <= SEG_OFF;
      frame_start_r <= 1'b0;
    end else begin
      sel_r         <= sel_nxt_s;
      seg_r         <= seg_nxt_s;
      frame_start_r <= wrap_s;
    end
  end

  assign bus.io_sel      = sel_r;
  assign bus.io_seg      = seg_r;
  assign bus.frame_start = frame_start_r;

endmodule : seven_seg_scan_driver

// File: tb/tb_seven_seg_scan_driver.sv
// Self-checking bench for seven_seg_scan_driver (N=4, slot 5 cycles, blink half period 50).
module tb_seven_seg_scan_driver;

  localparam int N    = 4;
  localparam int T    = 5;     // 1000 / (50 * 4)
  localparam int HALF = 50;    // 1000 / (2 * 10)
  localparam int TN   = T * N;

  logic clk;
  logic rst;

  seven_seg_scan_driver_if #(.NUM_DIGITS(N)) bus ();

  seven_seg_scan_driver #(
    .NUM_DIGITS     (N),
    .CLK_HZ         (1000),
    .REFRESH_HZ     (50),
    .BLINK_HZ       (10),
    .SEL_ACTIVE_LOW (1),
    .SEG_ACTIVE_LOW (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      if (bad <= 25) $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Glyphs written from segment letters, bit0=a ... bit6=g.
  logic [6:0] glyph_tab [0:15] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // What the pins show for cycle c after release, given the frame's data and live brightness.
  function automatic logic [11:0] model_out(input int c, input logic [15:0] num,
                                            input logic [3:0] dp, input logic [3:0] blink,
                                            input logic blank_en, input logic [3:0] br);
    int         dg;
    logic [3:0] nib;
    logic       blank;
    logic [7:0] pat;
    logic [3:0] sel;
    logic [3:0] one;
    dg    = (c / T) % N;
    nib   = 4'((num >> (4 * dg)) & 16'hF);
    blank = blank_en && (dg != 0) && ((num >> (4 * dg)) == 16'h0);
    pat   = {dp[dg], blank ? 7'h00 : glyph_tab[nib]};
    if ((((c / HALF) % 2) == 1) && blink[dg]) pat = 8'h00;
    one = 4'b0001;
    if ((br == 4'd15) || ((c % 16) < int'(br))) sel = ~(one << dg);
    else sel = 4'b1111;
    return {sel, ~pat};
  endfunction

  int         m_c;
  logic       m_first;
  logic [15:0] m_num;
  logic [3:0]  m_dp, m_blink;
  logic        m_blank;
  logic [3:0]  exp_sel;
  logic [7:0]  exp_seg;
  logic        exp_fs;
  logic        chk_en = 1'b0;

  // Reference model: cycle counter since release plus a per-frame copy of the inputs.
  always @(posedge clk) begin
    if (rst) begin
      m_c     <= 0;
      m_first <= 1'b1;
      m_num   <= 16'h0;
      m_dp    <= 4'h0;
      m_blink <= 4'h0;
      m_blank <= 1'b0;
      exp_sel <= 4'hF;
      exp_seg <= 8'hFF;
      exp_fs  <= 1'b0;
    end else begin
      if (m_first)
        {exp_sel, exp_seg} <= model_out(m_c, bus.number, bus.dp_mask, bus.blink_mask,
                                        bus.blank_lz, bus.brightness);
      else
        {exp_sel, exp_seg} <= model_out(m_c, m_num, m_dp, m_blink, m_blank, bus.brightness);
      exp_fs <= (((m_c + 1) % TN) == 0);
      if (m_first || (((m_c + 1) % TN) == 0)) begin
        m_num   <= bus.number;
        m_dp    <= bus.dp_mask;
        m_blink <= bus.blink_mask;
        m_blank <= bus.blank_lz;
      end
      m_first <= 1'b0;
      m_c     <= m_c + 1;
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("sel", 32'(bus.io_sel), 32'(exp_sel));
      check("seg", 32'(bus.io_seg), 32'(exp_seg));
      check("frame_start", 32'(bus.frame_start), 32'(exp_fs));
    end
  end

  initial begin
    int   cnt;
    logic found;
    logic [3:0] seen;

    rst            = 1'b1;
    bus.number     = 16'h12A7;
    bus.dp_mask    = 4'h0;
    bus.blink_mask = 4'h0;
    bus.blank_lz   = 1'b0;
    bus.brightness = 4'd15;
    @(posedge clk);
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_sel", 32'(bus.io_sel), 32'h0000000F);
    check("rst_seg", 32'(bus.io_seg), 32'h000000FF);
    check("rst_fs", 32'(bus.frame_start), 32'h0);

    // Release: digit 0 within one cycle, then the 12A7 glyphs per digit.
    rst = 1'b0;
    @(negedge clk);
    check("rel_d0", 32'(bus.io_sel), 32'h0000000E);
    seen = 4'h0;
    repeat (40) begin
      @(negedge clk);
      case (bus.io_sel)
        4'b1110: begin seen[0] = 1'b1; check("t2_d0", 32'(bus.io_seg), 32'h000000F8); end
        4'b1101: begin seen[1] = 1'b1; check("t2_d1", 32'(bus.io_seg), 32'h00000088); end
        4'b1011: begin seen[2] = 1'b1; check("t2_d2", 32'(bus.io_seg), 32'h000000A4); end
        4'b0111: begin seen[3] = 1'b1; check("t2_d3", 32'(bus.io_seg), 32'h000000F9); end
        default: ;
      endcase
    end
    check("t2_seen", 32'(seen), 32'h0000000F);

    // Leading-zero blanking, then all-zero with the top DP set.
    bus.number = 16'h0040;
    bus.blank_lz = 1'b1;
    repeat (45) @(negedge clk);
    bus.number  = 16'h0000;
    bus.dp_mask = 4'b1000;
    repeat (45) @(negedge clk);

    // Blink on digit 0 across several phases.
    bus.number = 16'h5678;
    bus.dp_mask = 4'b0001;
    bus.blank_lz = 1'b0;
    bus.blink_mask = 4'b0001;
    repeat (230) @(negedge clk);
    bus.blink_mask = 4'b0000;

    // Mid-frame change 8 cycles after a frame start.
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (bus.frame_start) found = 1'b1;
    end
    check("t5_frame", 32'(found), 32'h1);
    repeat (8) @(negedge clk);
    bus.number = 16'h9BCD;
    repeat (50) @(negedge clk);

    // PWM duty.
    bus.brightness = 4'd4;
    repeat (2) @(negedge clk);
    cnt = 0;
    repeat (64) begin
      @(negedge clk);
      if (bus.io_sel != 4'b1111) cnt++;
    end
    check("t6_duty4", 32'(cnt), 32'd16);
    bus.brightness = 4'd0;
    repeat (2) @(negedge clk);
    cnt = 0;
    repeat (32) begin
      @(negedge clk);
      if (bus.io_sel != 4'b1111) cnt++;
    end
    check("t6_duty0", 32'(cnt), 32'd0);

    // Reset in the middle of digit 2's slot.
    bus.brightness = 4'd15;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (bus.io_sel == 4'b1011) found = 1'b1;
    end
    check("t6_idx2", 32'(found), 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_sel", 32'(bus.io_sel), 32'h0000000F);
    check("t6_rst_seg", 32'(bus.io_seg), 32'h000000FF);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6_restart", 32'(bus.io_sel), 32'h0000000E);

    // Random traffic, including occasional resets.
    repeat (4000) begin
      @(negedge clk);
      rst = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 7) == 0)  bus.number     = 16'($urandom_range(0, 65535));
      if ($urandom_range(0, 3) == 0)  bus.number     = bus.number & 16'h00FF;
      if ($urandom_range(0, 15) == 0) bus.dp_mask    = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) bus.blink_mask = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) bus.blank_lz   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 31) == 0) bus.brightness = 4'($urandom_range(0, 15));
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_seven_seg_scan_driver
